// File: rtl/multi_wave_gen_pkg.sv
// Shared definitions for the multi-waveform generator: mode encoding, LFSR seed/taps
// and the LFSR step function.
package multi_wave_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW   = 2'd0,
    WAVE_TRI   = 2'd1,
    WAVE_SQR   = 2'd2,
    WAVE_NOISE = 2'd3
  } wave_mode_e;

  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/multi_wave_gen_if.sv
// Control and sample bus of the multi-waveform generator. The master drives
// the controls; the slave (the generator) returns the sample and wrap pulse.
interface multi_wave_gen_if #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
);
  logic               enable;
  logic               sync;
  logic [PHASE_W-1:0] freq_inc;
  logic [1:0]         mode;
  logic [OUT_W-1:0]   pulse_width;
  logic [OUT_W-1:0]   out;
  logic               wrap;

  modport master (
    output enable, sync, freq_inc, mode, pulse_width,
    input  out, wrap
  );

  modport slave (
    input  enable, sync, freq_inc, mode, pulse_width,
    output out, wrap
  );
endinterface

// File: rtl/multi_wave_gen_lfsr.sv
// 16-bit Galois LFSR noise source for the waveform generator; advances one
// step per step_i pulse. Only instantiated under MULTI_WAVE_GEN_NOISE_EN.
module wave_lfsr
  import multi_wave_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (step_i) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LFSR_SEED;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/multi_wave_gen.sv
// Phase-accumulator waveform generator (saw / triangle / square / noise).
// Optional noise source enabled by defining MULTI_WAVE_GEN_NOISE_EN.
module multi_wave_gen
  import multi_wave_gen_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  multi_wave_gen_if.slave  bus
);

  logic [PHASE_W-1:0] p_q, p_d;
  logic               wrap_q, wrap_d;
  wave_mode_e         mode_q, mode_d;
  logic [OUT_W-1:0]   out_q, out_d;

  logic [PHASE_W:0]   sum;
  logic               advance;
  logic               carry;
  logic [OUT_W:0]     t;
  logic [OUT_W-1:0]   s;
  logic [OUT_W-1:0]   noise_sample;

  assign advance = bus.enable & ~bus.sync;
  assign sum     = {1'b0, p_q} + {1'b0, bus.freq_inc};
  assign carry   = advance & sum[PHASE_W];

`ifdef MULTI_WAVE_GEN_NOISE_EN
  logic [LFSR_W-1:0] lfsr_state;

  wave_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  (carry),
    .state_o (lfsr_state)
  );

  assign noise_sample = lfsr_state[OUT_W-1:0];
`else
  assign noise_sample = '0;
`endif

  // Next-state: phase, wrap flag and the deferred mode select.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    p_d    = p_q;
    wrap_d = 1'b0;
    mode_d = mode_q;
    if (bus.sync) begin
      p_d = '0;
    end else if (bus.enable) begin
      p_d    = sum[PHASE_W-1:0];
      wrap_d = carry;
    end
    // Mode switches only at a period boundary or while the phase is frozen.
    if (bus.sync || carry || !bus.enable) mode_d = wave_mode_e'(bus.mode);
  end

  // Sample shaping from the current phase and active mode.
  always_comb begin
    t     = p_q[PHASE_W-1 -: OUT_W+1];
    s     = p_q[PHASE_W-1 -: OUT_W];
    out_d = '0;
    unique case (mode_q)
      WAVE_SAW:   out_d = s;
      WAVE_TRI:   out_d = t[OUT_W] ? ~t[OUT_W-1:0] : t[OUT_W-1:0];
      WAVE_SQR:   out_d = (s < bus.pulse_width) ? '1 : '0;
      WAVE_NOISE: out_d = noise_sample;
      default:    out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      wrap_q <= 1'b0;
      mode_q <= WAVE_SAW;
      out_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      p_q    <= p_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
      out_q  <= out_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// Self-checking bench for multi_wave_gen against a cycle-level arithmetic model.
module tb_multi_wave_gen;

  localparam int PHASE_W = 16;
  localparam int OUT_W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               en = 1'b0;
  logic               sy = 1'b0;
  logic [PHASE_W-1:0] fi = '0;
  logic [1:0]         md = '0;
  logic [OUT_W-1:0]   pw = '0;

  multi_wave_gen_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

  assign bus.enable      = en;
  assign bus.sync        = sy;
  assign bus.freq_inc    = fi;
  assign bus.mode        = md;
  assign bus.pulse_width = pw;

  multi_wave_gen #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned p_m, mode_m, lfsr_m, out_m, wrap_m, tap_mask;

  function automatic int unsigned build_tap_mask();
    int unsigned m = 0;
    int exps[4] = '{16, 14, 13, 11};
    foreach (exps[i]) m |= (1 << (exps[i] - 1));
    return m;
  endfunction

  function automatic int unsigned wave_of(int unsigned p, int unsigned m,
                                          int unsigned width, int unsigned noise);
    int unsigned tri_pos;
    case (m)
      0: return p / 256;
      1: begin
        tri_pos = p / 128;
        return (tri_pos < 256) ? tri_pos : 511 - tri_pos;
      end
      2: return ((p / 256) < width) ? 255 : 0;
      default: begin
`ifdef MULTI_WAVE_GEN_NOISE_EN
        return noise % 256;
`else
        return 0;
`endif
      end
    endcase
  endfunction

  task automatic model_reset();
    p_m    = 0;
    mode_m = 0;
    lfsr_m = 16'hACE1;
    out_m  = 0;
    wrap_m = 0;
  endtask

  // Advance model by one clock using current inputs, then compare after the edge.
  task automatic step(input string tag);
    int unsigned sum;
    bit carry;
    sum   = p_m + fi;
    out_m = wave_of(p_m, mode_m, pw, lfsr_m);
    carry = en && !sy && (sum > 65535);
    if (sy)      p_m = 0;
    else if (en) p_m = sum % 65536;
    wrap_m = carry;
    if (sy || carry || !en) mode_m = md;
    if (carry) lfsr_m = (lfsr_m & 1) ? ((lfsr_m >> 1) ^ tap_mask) : (lfsr_m >> 1);
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== OUT_W'(out_m)) begin
      bad++;
      $display("FAIL %s out: got %0d expected %0d at %0t", tag, bus.out, out_m, $time);
    end
    total++;
    if (bus.wrap !== 1'(wrap_m)) begin
      bad++;
      $display("FAIL %s wrap: got %0b expected %0b at %0t", tag, bus.wrap, wrap_m, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 0; sy = 0; fi = '0; md = '0; pw = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (bus.out !== '0 || bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got out=%0d wrap=%0b expected out=0 wrap=0", bus.out, bus.wrap);
    end
    do_reset();
  endtask

  task automatic test_saw();
    int wraps = 0;
    do_reset();
    md = 0; fi = 16'd256; en = 1;
    for (int i = 0; i < 512; i++) begin
      step("saw");
      if (bus.wrap === 1'b1) wraps++;
    end
    total++;
    if (wraps != 2) begin
      bad++;
      $display("FAIL saw_wrap_count: got %0d expected 2", wraps);
    end
  endtask

  task automatic test_triangle();
    do_reset();
    md = 1;
    en = 0;
    step("tri_load");
    fi = 16'd128; en = 1;
    for (int i = 0; i < 1030; i++) step("triangle");
  endtask

  task automatic test_square();
    do_reset();
    md = 2; pw = 8'd64;
    step("sqr_load");
    fi = 16'd256; en = 1;
    for (int i = 0; i < 520; i++) step("square64");
    pw = 8'd0;
    for (int i = 0; i < 260; i++) step("square0");
  endtask

  task automatic test_mode_switch();
    do_reset();
    md = 0; fi = 16'd256; en = 1;
    while (p_m != 32'h4000) step("switch_pre");
    md = 1;
    for (int i = 0; i < 300; i++) step("switch_deferred");
    en = 0; md = 2; pw = 8'd100;
    step("switch_idle");
    for (int i = 0; i < 3; i++) step("switch_idle_hold");
  endtask

  task automatic test_sync();
    do_reset();
    md = 0; fi = 16'd300; en = 1;
    for (int i = 0; i < 100; i++) step("sync_pre");
    en = 0; sy = 1;
    step("sync_pulse");
    sy = 0;
    step("sync_after");
    total++;
    if (bus.out !== '0) begin
      bad++;
      $display("FAIL sync_out_zero: got %0d expected 0", bus.out);
    end
    // sync in the very cycle an overflow would occur must suppress the wrap
    en = 1; fi = 16'hFFFF;
    step("sync_pre2");
    sy = 1;
    step("sync_blocks_wrap");
    sy = 0;
    for (int i = 0; i < 5; i++) step("sync_post");
  endtask

  task automatic test_async_reset();
    do_reset();
    md = 0; fi = 16'd1000; en = 1;
    for (int i = 0; i < 40; i++) step("areset_pre");
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out !== '0 || bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got out=%0d wrap=%0b expected out=0 wrap=0", bus.out, bus.wrap);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) step("areset_post");
  endtask

  task automatic test_noise();
    do_reset();
    md = 3;
    step("noise_load");
    fi = 16'h8000; en = 1;
    for (int i = 0; i < 200; i++) step("noise");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((i % 64) == 0) fi = ($urandom_range(0, 3) == 0) ? PHASE_W'($urandom_range(0, 4)) : PHASE_W'($urandom);
      en = ($urandom_range(0, 9) != 0);
      sy = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) md = 2'($urandom);
      if ($urandom_range(0, 31) == 0) pw = OUT_W'($urandom);
      step("random");
    end
  endtask

  initial begin
    tap_mask = build_tap_mask();
    model_reset();
    test_reset();
    test_saw();
    test_triangle();
    test_square();
    test_mode_switch();
    test_sync();
    test_async_reset();
    test_noise();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_wave_gen.md
MULTI_WAVE_GEN -- requirements
Module: multi_wave_gen

Interface
REQ-001 Parameter PHASE_W, default 16: phase accumulator width, SHALL be >= OUT_W+1.
REQ-002 Parameter OUT_W, default 8: output sample width, SHALL be in 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  phase advances only while high.
REQ-006 sync  input  1  phase restart strobe; takes priority over enable.
REQ-007 freq_inc  input  PHASE_W  phase increment per enabled cycle.
REQ-008 mode  input  2  requested waveform: 0 saw, 1 triangle, 2 square, 3 noise.
REQ-009 pulse_width  input  OUT_W  square-wave duty threshold.
REQ-010 out  output  OUT_W  registered sample.
REQ-011 wrap  output  1  one-cycle pulse on phase overflow.

Function
REQ-012 Phase register p SHALL update as p <= p + freq_inc, modulo 2^PHASE_W, each cycle enable=1 and sync=0; it SHALL hold when enable=0.
REQ-013 wrap SHALL be registered, high for exactly the one cycle in which p first holds a value produced by an addition that carried out; freq_inc=0 never wraps.
REQ-014 The active mode register SHALL load mode only on a wrapping addition, on sync, or in any cycle with enable=0; mode changes at other times SHALL be deferred.
REQ-015 Let t = p[PHASE_W-1 -: OUT_W+1] (top OUT_W+1 bits) and s = p[PHASE_W-1 -: OUT_W].
REQ-016 Saw: out SHALL equal s.
REQ-017 Triangle: out SHALL equal t[OUT_W-1:0] when t[OUT_W]=0, else its bitwise inverse.
REQ-018 Square: out SHALL be all ones when s < pulse_width (unsigned), else zero; pulse_width=0 gives constant zero.
REQ-019 out SHALL be computed from the current p and active mode and registered: one-cycle latency from p to out.
REQ-020 sync=1 SHALL set p to 0, load the active mode, and clear wrap, independent of enable.
REQ-021 Mode 3 behaviour SHALL be as defined under Configuration.

Reset
REQ-022 On rst_n=0: p=0, out=0, wrap=0, active mode=0 (saw), LFSR=16'hACE1 if present, immediately and asynchronously.
REQ-023 Reset asserted mid-period SHALL abandon the period; the first post-reset edge SHALL behave as from a fresh start.

Configuration
REQ-024 Macro MULTI_WAVE_GEN_NOISE_EN: when defined, a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 16'hACE1) SHALL step once per wrapping addition and mode 3 SHALL output lfsr[OUT_W-1:0].
REQ-025 Without MULTI_WAVE_GEN_NOISE_EN, no LFSR SHALL be synthesised and mode 3 SHALL output constant zero.

Structure
REQ-026 A shared package SHALL hold the mode encoding (WAVE_SAW, WAVE_TRI, WAVE_SQR, WAVE_NOISE), the LFSR seed and the tap mask.
REQ-027 The LFSR SHALL be a separate sub-module, wave_lfsr, instantiated only under MULTI_WAVE_GEN_NOISE_EN.

Verification (defaults PHASE_W=16, OUT_W=8)
REQ-028 Saw, freq_inc=256, enable=1 after reset -> out steps 0,1,...,255,0 one per cycle; wrap high once every 256 cycles.
REQ-029 Triangle, freq_inc=128 -> out 0..255 then 255..0, period 512 cycles, no skipped or extra code at either peak.
REQ-030 Square, freq_inc=256, pulse_width=64 -> 64 cycles of 8'hFF, then 192 cycles of 8'h00, repeating.
REQ-031 Mode switched saw->triangle at phase 16'h4000 -> saw continues until wrap, then triangle starts from out=0; enable=0 plus a mode change -> switch takes effect on the next edge.
REQ-032 sync pulse mid-period with enable=0 -> p=0, out=0 one cycle later, no wrap pulse; reset asserted mid-period -> out=0 immediately.
REQ-033 Noise, macro defined, freq_inc=16'h8000 -> out changes every 2 cycles following the LFSR sequence from 16'hACE1; macro undefined -> out stays 0.
